// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
//   Shared definitions for the instruction/data memory arbiter.
//   - state_t      : arbiter FSM encoding (3 bits)
//   - OWN_IF/OWN_D : which requester owns the outstanding transaction
//   - word-address helpers: byte offset width and the low bit of the word
//     address inside a byte address
//   - CNT_W        : width of the starvation counter (covers MAX_DATA_WINS 1..7)
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // A byte address splits into {word address, byte offset}.
    localparam int BYTE_OFF_W = 2;
    localparam int WORD_LSB   = BYTE_OFF_W;

    localparam int CNT_W = 3;

endpackage

// File: rtl/riscv_mem_arb_prio.sv
// -----------------------------------------------------------------------------
// riscv_mem_arb_prio
//   Priority selection between the fetch and data ports, plus the saturating
//   starvation counter that eventually forces a fetch grant.
//
//   Ports:
//     clock     in   system clock
//     reset_n   in   asynchronous active-low reset
//     if_req    in   fetch port is requesting
//     d_req     in   data port is requesting
//     grant_en  in   the arbiter is able to accept a request this cycle
//     sel_d     out  data port is the winner (meaningful when grant = 1)
//     grant     out  a request is accepted this cycle
//
//   Data wins ties until it has won MAX_DATA_WINS times in a row against a
//   waiting fetch; at that point fetch wins once and the count restarts.
// -----------------------------------------------------------------------------
module riscv_mem_arb_prio
    import riscv_mem_pkg::*;
#(
    parameter int MAX_DATA_WINS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic sel_d,
    output logic grant
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_WINS);

    logic [CNT_W-1:0] win_cnt;
    logic             force_if;

    // Fetch is only forced when it is actually waiting.
    assign force_if = if_req && (win_cnt == CNT_MAX);
    assign sel_d    = d_req && !force_if;
    assign grant    = grant_en && (if_req || d_req);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt <= '0;
        end else if (grant) begin
            if (sel_d) begin
                // Only a win over a waiting fetch counts as starving it.
                if (if_req && (win_cnt != CNT_MAX)) begin
                    win_cnt <= win_cnt + CNT_W'(1);
                end
            end else begin
                win_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
//   Shares one single-ported, variable-latency word memory between the
//   instruction-fetch port and the load/store port of the core. One
//   transaction is outstanding at a time; the data port has priority with a
//   starvation guard for fetch (see riscv_mem_arb_prio).
//
//   Ports:
//     clock, reset_n          clock, asynchronous active-low reset
//     if_req/if_addr          fetch request (held until if_gnt)
//     if_gnt                  fetch accepted (combinational, IDLE only)
//     if_rvalid/if_rdata      one-cycle fetch response
//     d_req/d_we/d_addr/d_wdata  load/store request (held until d_gnt)
//     d_gnt                   data accepted (combinational, IDLE only)
//     d_rvalid/d_rdata/d_err  one-cycle data response; d_err marks a
//                             misaligned access that never reached memory
//     mem_req/mem_we/mem_addr/mem_wdata  registered request to memory,
//                             mem_addr is the word address
//     mem_ready               memory accepts mem_req this cycle
//     mem_rvalid/mem_rdata    memory response, exactly one per request
//     dbg_state               current FSM state, for observation only
//
//   Handshake: a request is held until its grant; the grant is the accept
//   strobe. On the memory side mem_req is held with stable address/data
//   until mem_ready; exactly one mem_rvalid follows, no earlier than the
//   cycle after mem_ready. Responses are single-cycle rvalid pulses with no
//   back-pressure.
//
//   Timing: grant at N, mem_req at N+1, best case rvalid at N+3 (ISSUE,
//   WAIT, RESP each one cycle). A misaligned data access responds at N+2.
// -----------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DATA_WINS = 4   // legal range 1..7
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [2:0]        dbg_state
);

    state_t state;
    logic   owner;

    logic   grant_en;
    logic   grant;
    logic   sel_d;

    logic [ADDR_W-1:0] win_addr;
    logic              misaligned;

    assign grant_en = (state == IDLE);

    riscv_mem_arb_prio #(
        .MAX_DATA_WINS (MAX_DATA_WINS)
    ) u_prio (
        .clock    (clock),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .sel_d    (sel_d),
        .grant    (grant)
    );

    assign if_gnt = grant && !sel_d;
    assign d_gnt  = grant &&  sel_d;

    // Winner's byte address. Only data accesses are alignment-checked; the
    // fetch byte offset is simply dropped when forming the word address.
    assign win_addr   = sel_d ? d_addr : if_addr;
    assign misaligned = sel_d && (win_addr[BYTE_OFF_W-1:0] != '0);

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            // Response strobes are single-cycle unless set below.
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= sel_d ? OWN_D : OWN_IF;
                        mem_addr  <= win_addr[ADDR_W-1:WORD_LSB];
                        mem_we    <= sel_d && d_we;
                        mem_wdata <= sel_d ? d_wdata : '0;
                        if (misaligned) begin
                            state <= ERR;
                        end else begin
                            mem_req <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // mem_rvalid is not looked at here: the memory never
                    // answers in the same cycle it accepts.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        state <= RESP;
                    end
                end

                // The response pulse is visible during RESP; no grant here.
                RESP: begin
                    state <= IDLE;
                end

                ERR: begin
                    d_rvalid <= 1'b1;
                    d_err    <= 1'b1;
                    d_rdata  <= '0;
                    state    <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic              if_req = 0, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 0, d_we = 0, d_gnt, d_rvalid, d_err;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0, d_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 0, mem_rvalid = 0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [2:0]        dbg_state;

    riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_WINS(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Default content of a never-written memory word.
    function automatic logic [31:0] pat(input logic [29:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem_store [logic [29:0]];
    int          ready_delay = 0;
    bit          hold_resp   = 0;
    bit          inject_stray = 0;
    int          req_cycles  = 0;
    int          stall_cnt   = 0;
    bit          pending     = 0;
    logic [31:0] pend_data   = '0;

    initial forever begin
        @(negedge clock);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if (inject_stray) begin
            mem_rvalid   = 1'b1;
            mem_rdata    = 32'h0BAD_0BAD;
            inject_stray = 0;
        end else if (pending && !hold_resp) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_data;
        end
        pending = 0;
        if (mem_req) begin
            req_cycles++;
            if (stall_cnt >= ready_delay) begin
                mem_ready = 1'b1;
                stall_cnt = 0;
                pending   = 1;
                if (mem_we) begin
                    mem_store[mem_addr] = mem_wdata;
                    pend_data = 32'hA5A5_A5A5;
                end else begin
                    pend_data = mem_store.exists(mem_addr) ? mem_store[mem_addr] : pat(mem_addr);
                end
            end else begin
                stall_cnt++;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0]       ref_mem [logic [29:0]];
    logic [DATA_W+2:0] exp_q[$];   // {if_rvalid, d_rvalid, d_err, data}
    int                resp_count = 0;
    int                resp_cycle = 0;

    function automatic logic [31:0] ref_read(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : pat(wa);
    endfunction

    task automatic push_exp(input logic is_d, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (is_d && (addr[1:0] != 2'b00))
            exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
        else if (is_d && we) begin
            ref_mem[addr[31:2]] = wdata;
            exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0});
        end else if (is_d)
            exp_q.push_back({1'b0, 1'b1, 1'b0, ref_read(addr[31:2])});
        else
            exp_q.push_back({1'b1, 1'b0, 1'b0, ref_read(addr[31:2])});
    endtask

    // Monitor: every rvalid pulse pops one expected response.
    initial forever begin
        logic [DATA_W+2:0] exp_v;
        @(negedge clock);
        #2;
        if (if_rvalid || d_rvalid) begin
            resp_count++;
            resp_cycle = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got if_rvalid=%0b d_rvalid=%0b expected no response",
                         if_rvalid, d_rvalid);
            end else begin
                exp_v = exp_q.pop_front();
                check("response", {if_rvalid, d_rvalid, d_err, (d_rvalid ? d_rdata : if_rdata)}, exp_v);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 80 && exp_q.size() != 0; n++) @(negedge clock);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
    endtask

    task automatic do_txn(input int idx, input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input int lat, input logic err);
        int g_cycle, r0, rc0;
        bit got;
        ready_delay = delay;
        @(negedge clock);
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        got = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (if_gnt || d_gnt) begin got = 1; break; end
            @(negedge clock);
        end
        check($sformatf("v%0d_gnt", idx), {if_gnt, d_gnt}, is_d ? 2'b01 : 2'b10);
        g_cycle = cyc;
        r0      = resp_count;
        rc0     = req_cycles;
        if (got) push_exp(is_d, we, addr, wdata);
        @(negedge clock);
        if_req = 0;
        d_req  = 0;
        if (!got) return;
        #1;
        check($sformatf("v%0d_mem_req", idx), mem_req, !err);
        if (!err) begin
            check($sformatf("v%0d_mem_addr", idx), mem_addr, addr[31:2]);
            check($sformatf("v%0d_mem_we", idx), mem_we, is_d & we);
        end
        got = 0;
        for (int n = 0; n < 40; n++) begin
            if (resp_count != r0) begin got = 1; break; end
            @(negedge clock);
            #3;
        end
        check($sformatf("v%0d_latency", idx), got ? (resp_cycle - g_cycle) : 999, lat);
        if (err) check($sformatf("v%0d_no_mem_req", idx), req_cycles - rc0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          lat;
        logic        err;
    } vec_t;

    vec_t tbl[9];

    // ---------------- main sequence ----------------
    initial begin
        int          g, r0, ng;
        bit          got;
        logic        order[10];
        logic [0:9]  exp_order;

        tbl[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         0, 3, 1'b0}; // fetch, preloaded 0x13
        tbl[1] = '{1'b1, 1'b1, 32'h20,  32'hDEADBEEF,  0, 3, 1'b0}; // store
        tbl[2] = '{1'b1, 1'b0, 32'h20,  32'h0,         0, 3, 1'b0}; // load back
        tbl[3] = '{1'b1, 1'b0, 32'h22,  32'h0,         0, 2, 1'b1}; // misaligned load
        tbl[4] = '{1'b1, 1'b1, 32'h31,  32'h12345678,  0, 2, 1'b1}; // misaligned store
        tbl[5] = '{1'b0, 1'b0, 32'h13,  32'h0,         0, 3, 1'b0}; // fetch offset dropped
        tbl[6] = '{1'b1, 1'b1, 32'h100, $urandom(),    2, 5, 1'b0}; // store, slow ready
        tbl[7] = '{1'b1, 1'b0, 32'h100, 32'h0,         1, 4, 1'b0}; // load, slow ready
        tbl[8] = '{1'b0, 1'b0, 32'h20,  32'h0,         0, 3, 1'b0}; // fetch sees stored word

        mem_store[30'h4] = 32'h0000_0013;
        ref_mem[30'h4]   = 32'h0000_0013;

        // Reset state
        #3;
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_d_rvalid",  d_rvalid,  0);
        check("rst_d_err",     d_err,     0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_d_rdata",   d_rdata,   0);
        check("rst_state",     dbg_state, IDLE);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 9; i++)
            do_txn(i, tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                   tbl[i].delay, tbl[i].lat, tbl[i].err);
        wait_drain("table_drain");
        check("d_rdata_hold", d_rdata, tbl[6].wdata);

        // Stall: mem_ready low for 5 cycles, data request waits behind it
        ready_delay = 5;
        @(negedge clock);
        if_req = 1; if_addr = 32'h44;
        #1;
        check("stall_if_gnt", if_gnt, 1);
        g = cyc;
        if (if_gnt) push_exp(1'b0, 1'b0, 32'h44, 32'h0);
        @(negedge clock);
        if_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h48;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("stall_mem_req_%0d", k),  mem_req,  1);
            check($sformatf("stall_mem_addr_%0d", k), mem_addr, 30'h11);
            check($sformatf("stall_no_gnt_%0d", k),   d_gnt,    0);
            @(negedge clock);
        end
        got = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (d_gnt) begin got = 1; break; end
            @(negedge clock);
        end
        check("stall_d_gnt_cycle", got ? (cyc - g) : 999, 9);
        if (got) push_exp(1'b1, 1'b0, 32'h48, 32'h0);
        @(negedge clock);
        d_req = 0;
        wait_drain("stall_drain");

        // Contention: both requesters held high
        apply_reset();
        ready_delay = 0;
        @(negedge clock);
        if_req = 1; if_addr = 32'h80;
        d_req = 1;  d_we = 0; d_addr = 32'h84;
        ng = 0;
        for (int n = 0; n < 100 && ng < 10; n++) begin
            #1;
            check("cont_gnt_excl", if_gnt & d_gnt, 0);
            if (if_gnt) begin
                order[ng] = 1'b0; ng++;
                push_exp(1'b0, 1'b0, 32'h80, 32'h0);
            end else if (d_gnt) begin
                order[ng] = 1'b1; ng++;
                push_exp(1'b1, 1'b0, 32'h84, 32'h0);
            end
            @(negedge clock);
        end
        if_req = 0;
        d_req  = 0;
        check("cont_grants", ng, 10);
        exp_order = 10'b1111011110;
        for (int i = 0; i < 10; i++)
            if (i < ng) check($sformatf("cont_order_%0d", i), order[i], exp_order[i]);
        wait_drain("cont_drain");

        // Reset in WAIT with a stray response after release
        hold_resp   = 1;
        ready_delay = 0;
        r0 = resp_count;
        @(negedge clock);
        if_req = 1; if_addr = 32'h200;
        #1;
        check("rst_mid_gnt", if_gnt, 1);
        @(negedge clock);
        if_req = 0;
        @(negedge clock);
        #1;
        check("rst_mid_in_wait", dbg_state, WAIT);
        reset_n = 1'b0;
        #1;
        check("rst_mid_state",     dbg_state, IDLE);
        check("rst_mid_mem_req",   mem_req,   0);
        check("rst_mid_mem_addr",  mem_addr,  0);
        check("rst_mid_mem_wdata", mem_wdata, 0);
        check("rst_mid_if_rvalid", if_rvalid, 0);
        check("rst_mid_if_rdata",  if_rdata,  0);
        @(negedge clock);
        @(negedge clock);
        #1;
        reset_n      = 1'b1;
        hold_resp    = 0;
        inject_stray = 1;
        repeat (4) @(negedge clock);
        #3;
        check("rst_stray_ignored", resp_count - r0, 0);
        check("rst_stray_state",   dbg_state, IDLE);
        do_txn(99, 1'b0, 1'b0, 32'h200, 32'h0, 0, 3, 1'b0);
        wait_drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
